rs_bank: RTL and testbench
==========================

# rs_bank

Reservation-station storage bank sitting directly downstream of the dispatch selector. It consumes the per-slot one-hot entry grants and writes dispatched instructions into those entries. It wakes up source operands from CDB tag broadcasts and issues ready entries into per-slot issue registers that feed the functional units. It returns its registered occupancy (`empty_vec`, `free_count`) to the selector and to dispatch stall logic.

## Interface
Parameters:
- `RS_DEPTH`, 16, number of entries
- `DISPATCH_WIDTH`, 2, dispatch slots per cycle
- `ISSUE_WIDTH`, 2, issue slots per cycle
- `CDB_WIDTH`, 2, tag broadcasts per cycle
- `PREG_BITS`, 6, physical-register tag width
- `ROB_BITS`, 5, ROB index width
- `PAYLOAD_W`, 32, opaque opcode/immediate payload

Ports (clock single; reset asynchronous, active-low):
- `clock` in 1: sole clock
- `reset_n` in 1: asynchronous active-low reset
- `flush` in 1: synchronous squash of all state
- `disp_valid` in [DISPATCH_WIDTH]: slot carries an instruction
- `disp_grant_vec` in [DISPATCH_WIDTH][RS_DEPTH]: one-hot target entry per slot, from selector
- `disp_dest_tag`, `disp_src1_tag`, `disp_src2_tag` in [DISPATCH_WIDTH][PREG_BITS]
- `disp_src1_ready`, `disp_src2_ready` in [DISPATCH_WIDTH]: operand already available
- `disp_rob_idx` in [DISPATCH_WIDTH][ROB_BITS]; `disp_payload` in [DISPATCH_WIDTH][PAYLOAD_W]
- `cdb_valid` in [CDB_WIDTH]; `cdb_tag` in [CDB_WIDTH][PREG_BITS]
- `fu_ready` in [ISSUE_WIDTH]: FU accepts issue register this cycle
- `issue_valid` out [ISSUE_WIDTH]; `issue_dest_tag`, `issue_src1_tag`, `issue_src2_tag`, `issue_rob_idx`, `issue_payload` out, per slot
- `empty_vec` out [RS_DEPTH]: registered, 1 = entry free
- `free_count` out [$clog2(RS_DEPTH+1)]: popcount of `empty_vec`, registered

## Operation
- Entry state: valid, src1_rdy, src2_rdy, tags, rob_idx, payload.
- Dispatch: for each slot i with `disp_valid[i]` and grant bit j set, write entry j. Grants with `disp_valid[i]`=0 are ignored.
- Wakeup: every valid entry sets srcN_rdy when any `cdb_valid[k]` has `cdb_tag[k]` equal to its srcN tag.
- Dispatch bypass: a dispatched source whose tag matches a same-cycle CDB broadcast is written ready.
- Eligible entry: valid & src1_rdy & src2_rdy, from registered bits only.
- Issue slot i accepts when `!issue_valid[i] || fu_ready[i]`.
- Picker: walks accepting slots in ascending order. Each takes the lowest-index eligible entry not taken by a lower slot.
- A picked entry is loaded into issue register i and its valid bit is cleared at the same edge.
- A non-accepting slot holds its contents; `fu_ready` with `issue_valid`=0 is harmless.
- Accepting slot with nothing picked: `issue_valid[i]` goes 0.
- Flush (highest priority): clears all entry valid bits and all `issue_valid`. Dispatch and CDB in the flush cycle are discarded.

## Timing
- Reset values: `empty_vec` all ones, `free_count`=RS_DEPTH, `issue_valid` 0, all issue fields 0, entry valid 0.
- Dispatch at edge N: `empty_vec[j]`=0 and `free_count` reduced after N.
- Entry ready at dispatch: eligible in cycle N+1, `issue_valid` high after edge N+1 (minimum dispatch-to-issue latency 1).
- CDB in cycle M: ready bit set at edge M, issue at edge M+1 at earliest.
- Issue at edge N frees the entry after N. The selector may re-grant it in cycle N+1, not N.
- Full bank: `empty_vec` all zero, so the selector grants nothing and no write occurs.
- Reset mid-operation clears everything immediately, independent of `clock`.

## Configuration
- `RS_BANK_ASSERT_EN` defined: SVA checks compiled in:
  - each `disp_grant_vec[i]` is zero or one-hot;
  - no two valid slots grant the same entry;
  - a valid grant targets only an entry with `empty_vec` = 1;
  - `issue_*` stable while `issue_valid & !fu_ready`.
- `RS_BANK_ASSERT_EN` undefined: no assertions; functional behaviour is identical.

## Structure
- Package `rs_pkg` holds `rs_entry_t` (packed entry struct), `issue_pkt_t`, and tag/ROB width constants shared with dispatch and the FUs.
- One sub-module, `rs_issue_picker`: combinational multi-grant over the eligible vector and slot-accept mask, producing per-slot one-hot grants. All state stays in `rs_bank`.

## Test plan
- Reset, then idle: `empty_vec`=16'hFFFF, `free_count`=16, `issue_valid`=0.
- Dispatch slot0 into entry 3 with both sources ready, `fu_ready`=1: `empty_vec[3]`=0 after edge N; `issue_valid[0]`=1 with entry 3 fields after N+1; `empty_vec[3]`=1 after N+1.
- Dispatch entry 5 with src1 tag 7 not ready, then `cdb_tag`=7 two cycles later: entry 5 issues exactly one edge after the broadcast.
- Dispatch with src2 tag 9 while CDB broadcasts 9 in the same cycle: entry issues after edge N+1.
- Entries 0, 2, 4 ready, `fu_ready`=2'b01 with slot1 holding a valid instruction: slot0 takes entry 0 and slot1 holds; next cycle with `fu_ready`=2'b11, slots take entries 2 and 4.
- Fill all 16 entries, then assert `flush` with a valid dispatch: after the edge `free_count`=16, `issue_valid`=0, and the dispatch is dropped.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the reservation-station bank: entry and issue-packet layouts,
// plus the tag/ROB/payload widths common to dispatch and the functional units.
package rs_pkg;

  localparam int TAG_W   = 6;
  localparam int ROB_W   = 5;
  localparam int PLD_W   = 32;
  localparam int CDB_N   = 2;

  typedef logic [TAG_W-1:0] preg_t;
  typedef logic [ROB_W-1:0] rob_t;
  typedef logic [PLD_W-1:0] payload_t;

  typedef struct packed {
    logic     valid;
    logic     src1_rdy;
    logic     src2_rdy;
    preg_t    dest_tag;
    preg_t    src1_tag;
    preg_t    src2_tag;
    rob_t     rob_idx;
    payload_t payload;
  } rs_entry_t;

  typedef struct packed {
    logic     valid;
    preg_t    dest_tag;
    preg_t    src1_tag;
    preg_t    src2_tag;
    rob_t     rob_idx;
    payload_t payload;
  } issue_pkt_t;

  // True when any valid broadcast this cycle carries the given tag.
  function automatic logic tag_hit(input logic [CDB_N-1:0] v,
                                   input logic [CDB_N-1:0][TAG_W-1:0] t,
                                   input preg_t tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_N; k++) begin
      if (v[k] && (t[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rs_issue_picker.sv
// Combinational multi-grant picker: each accepting slot, in ascending order,
// takes the lowest-index eligible entry not already taken by a lower slot.
module rs_issue_picker #(
  parameter int DEPTH = 16,
  parameter int SLOTS = 2
) (
  input  logic [DEPTH-1:0]            eligible,
  input  logic [SLOTS-1:0]            accept,
  output logic [SLOTS-1:0][DEPTH-1:0] grant
);

  logic [DEPTH-1:0] taken;
  logic             found;

  always_comb begin
    grant = '0;
    taken = '0;
    found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      found = 1'b0;
      if (accept[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (!found && eligible[j] && !taken[j]) begin
            grant[i][j] = 1'b1;
            taken[j]    = 1'b1;
            found       = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Reservation-station storage bank: dispatch write, CDB wakeup, multi-slot issue.
// Define RS_BANK_ASSERT_EN to compile in interface-protocol assertions.
module rs_bank
  import rs_pkg::*;
#(
  parameter int RS_DEPTH       = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int CDB_WIDTH      = CDB_N,
  parameter int PREG_BITS      = TAG_W,
  parameter int ROB_BITS       = ROB_W,
  parameter int PAYLOAD_W      = PLD_W,
  localparam int CNT_W         = $clog2(RS_DEPTH + 1)
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
  input  logic                                          flush,
  input  logic [DISPATCH_WIDTH-1:0]                     disp_valid,
  input  logic [DISPATCH_WIDTH-1:0][RS_DEPTH-1:0]       disp_grant_vec,
  input  logic [DISPATCH_WIDTH-1:0][PREG_BITS-1:0]      disp_dest_tag,
  input  logic [DISPATCH_WIDTH-1:0][PREG_BITS-1:0]      disp_src1_tag,
  input  logic [DISPATCH_WIDTH-1:0][PREG_BITS-1:0]      disp_src2_tag,
  input  logic [DISPATCH_WIDTH-1:0]                     disp_src1_ready,
  input  logic [DISPATCH_WIDTH-1:0]                     disp_src2_ready,
  input  logic [DISPATCH_WIDTH-1:0][ROB_BITS-1:0]       disp_rob_idx,
  input  logic [DISPATCH_WIDTH-1:0][PAYLOAD_W-1:0]      disp_payload,
  input  logic [CDB_WIDTH-1:0]                          cdb_valid,
  input  logic [CDB_WIDTH-1:0][PREG_BITS-1:0]           cdb_tag,
  input  logic [ISSUE_WIDTH-1:0]                        fu_ready,
  output logic [ISSUE_WIDTH-1:0]                        issue_valid,
  output logic [ISSUE_WIDTH-1:0][PREG_BITS-1:0]         issue_dest_tag,
  output logic [ISSUE_WIDTH-1:0][PREG_BITS-1:0]         issue_src1_tag,
  output logic [ISSUE_WIDTH-1:0][PREG_BITS-1:0]         issue_src2_tag,
  output logic [ISSUE_WIDTH-1:0][ROB_BITS-1:0]          issue_rob_idx,
  output logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]         issue_payload,
  output logic [RS_DEPTH-1:0]                           empty_vec,
  output logic [CNT_W-1:0]                              free_count
);

  // Issue handshake: slot i moves a new packet in whenever its register is empty
  // or the FU takes the current one (fu_ready); otherwise it holds unchanged.

  rs_entry_t  entry_q [RS_DEPTH];
  rs_entry_t  entry_d [RS_DEPTH];
  issue_pkt_t issue_q [ISSUE_WIDTH];
  issue_pkt_t issue_d [ISSUE_WIDTH];
  logic [RS_DEPTH-1:0] empty_vec_q, empty_vec_d;
  logic [CNT_W-1:0]    free_count_q, free_count_d;

  logic [RS_DEPTH-1:0]                  eligible;
  logic [ISSUE_WIDTH-1:0]               accept;
  logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0] pick;

  always_comb begin
    for (int j = 0; j < RS_DEPTH; j++) begin
      eligible[j] = entry_q[j].valid & entry_q[j].src1_rdy & entry_q[j].src2_rdy;
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      accept[i] = !issue_q[i].valid || fu_ready[i];
    end
  end

  rs_issue_picker #(
    .DEPTH (RS_DEPTH),
    .SLOTS (ISSUE_WIDTH)
  ) u_picker (
    .eligible (eligible),
    .accept   (accept),
    .grant    (pick)
  );

  // Entry update: wakeup, issue clear, dispatch write, then flush on top.
  always_comb begin
    for (int j = 0; j < RS_DEPTH; j++) begin
      entry_d[j] = entry_q[j];
      if (entry_q[j].valid) begin
        if (tag_hit(cdb_valid, cdb_tag, entry_q[j].src1_tag)) entry_d[j].src1_rdy = 1'b1;
        if (tag_hit(cdb_valid, cdb_tag, entry_q[j].src2_tag)) entry_d[j].src2_rdy = 1'b1;
      end
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (pick[i][j]) entry_d[j].valid = 1'b0;
      end
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (disp_valid[i] && disp_grant_vec[i][j]) begin
          entry_d[j].valid    = 1'b1;
          entry_d[j].src1_rdy = disp_src1_ready[i] | tag_hit(cdb_valid, cdb_tag, disp_src1_tag[i]);
          entry_d[j].src2_rdy = disp_src2_ready[i] | tag_hit(cdb_valid, cdb_tag, disp_src2_tag[i]);
          entry_d[j].dest_tag = disp_dest_tag[i];
          entry_d[j].src1_tag = disp_src1_tag[i];
          entry_d[j].src2_tag = disp_src2_tag[i];
          entry_d[j].rob_idx  = disp_rob_idx[i];
          entry_d[j].payload  = disp_payload[i];
        end
      end
    end
    if (flush) begin
      for (int j = 0; j < RS_DEPTH; j++) entry_d[j].valid = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      issue_d[i] = issue_q[i];
      if (accept[i]) begin
        issue_d[i].valid = 1'b0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (pick[i][j]) begin
            issue_d[i].valid    = 1'b1;
            issue_d[i].dest_tag = entry_q[j].dest_tag;
            issue_d[i].src1_tag = entry_q[j].src1_tag;
            issue_d[i].src2_tag = entry_q[j].src2_tag;
            issue_d[i].rob_idx  = entry_q[j].rob_idx;
            issue_d[i].payload  = entry_q[j].payload;
          end
        end
      end
      if (flush) issue_d[i].valid = 1'b0;
    end
  end

  // Occupancy is registered from next-state valid bits so it tracks entry_q exactly.
  always_comb begin
    free_count_d = '0;
    for (int j = 0; j < RS_DEPTH; j++) begin
      empty_vec_d[j] = ~entry_d[j].valid;
      free_count_d   = free_count_d + CNT_W'(empty_vec_d[j]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < RS_DEPTH; j++) entry_q[j] <= '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) issue_q[i] <= '0;
      empty_vec_q  <= '1;
      free_count_q <= CNT_W'(RS_DEPTH);
    end else begin
      for (int j = 0; j < RS_DEPTH; j++) entry_q[j] <= entry_d[j];
      for (int i = 0; i < ISSUE_WIDTH; i++) issue_q[i] <= issue_d[i];
      empty_vec_q  <= empty_vec_d;
      free_count_q <= free_count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      issue_valid[i]    = issue_q[i].valid;
      issue_dest_tag[i] = issue_q[i].dest_tag;
      issue_src1_tag[i] = issue_q[i].src1_tag;
      issue_src2_tag[i] = issue_q[i].src2_tag;
      issue_rob_idx[i]  = issue_q[i].rob_idx;
      issue_payload[i]  = issue_q[i].payload;
    end
  end

  assign empty_vec  = empty_vec_q;
  assign free_count = free_count_q;

`ifdef RS_BANK_ASSERT_EN
  genvar gi, gk;
  generate
    for (gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_disp_chk
      a_grant_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(disp_grant_vec[gi]));
      a_grant_free: assert property (@(posedge clock) disable iff (!reset_n)
        (disp_valid[gi] && !flush) |-> ((disp_grant_vec[gi] & ~empty_vec_q) == '0));
      for (gk = gi + 1; gk < DISPATCH_WIDTH; gk++) begin : g_pair
        a_grant_disjoint: assert property (@(posedge clock) disable iff (!reset_n)
          (disp_valid[gi] && disp_valid[gk]) |-> ((disp_grant_vec[gi] & disp_grant_vec[gk]) == '0));
      end
    end
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_issue_chk
      a_issue_hold: assert property (@(posedge clock) disable iff (!reset_n)
        (issue_q[gi].valid && !fu_ready[gi] && !flush) |=> $stable(issue_q[gi]));
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank: reset, dispatch/issue latency, wakeup, bypass,
// partial FU stall, full-bank flush and asynchronous mid-run reset.
module tb_rs_bank;

  localparam int D  = 16;
  localparam int DW = 2;
  localparam int IW = 2;
  localparam int CW = 2;
  localparam int PB = 6;
  localparam int RB = 5;
  localparam int PW = 32;

  logic                   clock;
  logic                   reset_n;
  logic                   flush;
  logic [DW-1:0]          disp_valid;
  logic [DW-1:0][D-1:0]   disp_grant_vec;
  logic [DW-1:0][PB-1:0]  disp_dest_tag, disp_src1_tag, disp_src2_tag;
  logic [DW-1:0]          disp_src1_ready, disp_src2_ready;
  logic [DW-1:0][RB-1:0]  disp_rob_idx;
  logic [DW-1:0][PW-1:0]  disp_payload;
  logic [CW-1:0]          cdb_valid;
  logic [CW-1:0][PB-1:0]  cdb_tag;
  logic [IW-1:0]          fu_ready;
  logic [IW-1:0]          issue_valid;
  logic [IW-1:0][PB-1:0]  issue_dest_tag, issue_src1_tag, issue_src2_tag;
  logic [IW-1:0][RB-1:0]  issue_rob_idx;
  logic [IW-1:0][PW-1:0]  issue_payload;
  logic [D-1:0]           empty_vec;
  logic [4:0]             free_count;

  int total = 0;
  int bad   = 0;

  rs_bank dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush           (flush),
    .disp_valid      (disp_valid),
    .disp_grant_vec  (disp_grant_vec),
    .disp_dest_tag   (disp_dest_tag),
    .disp_src1_tag   (disp_src1_tag),
    .disp_src2_tag   (disp_src2_tag),
    .disp_src1_ready (disp_src1_ready),
    .disp_src2_ready (disp_src2_ready),
    .disp_rob_idx    (disp_rob_idx),
    .disp_payload    (disp_payload),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .fu_ready        (fu_ready),
    .issue_valid     (issue_valid),
    .issue_dest_tag  (issue_dest_tag),
    .issue_src1_tag  (issue_src1_tag),
    .issue_src2_tag  (issue_src2_tag),
    .issue_rob_idx   (issue_rob_idx),
    .issue_payload   (issue_payload),
    .empty_vec       (empty_vec),
    .free_count      (free_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    flush           = 1'b0;
    disp_valid      = '0;
    disp_grant_vec  = '0;
    disp_dest_tag   = '0;
    disp_src1_tag   = '0;
    disp_src2_tag   = '0;
    disp_src1_ready = '0;
    disp_src2_ready = '0;
    disp_rob_idx    = '0;
    disp_payload    = '0;
    cdb_valid       = '0;
    cdb_tag         = '0;
  endtask

  task automatic disp(input int s, input int e, input int dt, input int t1, input logic r1,
                      input int t2, input logic r2, input int rob, input logic [31:0] pld);
    disp_valid[s]      = 1'b1;
    disp_grant_vec[s]  = 16'(1) << e;
    disp_dest_tag[s]   = PB'(dt);
    disp_src1_tag[s]   = PB'(t1);
    disp_src1_ready[s] = r1;
    disp_src2_tag[s]   = PB'(t2);
    disp_src2_ready[s] = r2;
    disp_rob_idx[s]    = RB'(rob);
    disp_payload[s]    = pld;
  endtask

  task automatic cdb(input int k, input int tag);
    cdb_valid[k] = 1'b1;
    cdb_tag[k]   = PB'(tag);
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr_inputs();
    fu_ready = 2'b11;
    reset_n  = 1'b0;
    #12;
    check("rst_empty", 64'(empty_vec), 64'hFFFF);
    check("rst_free", 64'(free_count), 64'd16);
    check("rst_iv", 64'(issue_valid), 64'd0);
    check("rst_rob0", 64'(issue_rob_idx[0]), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("idle_empty", 64'(empty_vec), 64'hFFFF);
    check("idle_free", 64'(free_count), 64'd16);
    check("idle_iv", 64'(issue_valid), 64'd0);

    // ready-at-dispatch into entry 3: one-cycle dispatch-to-issue
    disp(0, 3, 10, 1, 1'b1, 2, 1'b1, 3, 32'hA5A5_0003);
    step();
    clr_inputs();
    check("e3_empty_n", 64'(empty_vec), 64'hFFF7);
    check("e3_free_n", 64'(free_count), 64'd15);
    check("e3_iv_n", 64'(issue_valid), 64'd0);
    step();
    check("e3_iv", 64'(issue_valid), 64'b01);
    check("e3_dest", 64'(issue_dest_tag[0]), 64'd10);
    check("e3_src1", 64'(issue_src1_tag[0]), 64'd1);
    check("e3_src2", 64'(issue_src2_tag[0]), 64'd2);
    check("e3_rob", 64'(issue_rob_idx[0]), 64'd3);
    check("e3_pld", 64'(issue_payload[0]), 64'hA5A5_0003);
    check("e3_empty", 64'(empty_vec), 64'hFFFF);
    check("e3_free", 64'(free_count), 64'd16);
    step();
    check("e3_drain", 64'(issue_valid), 64'd0);

    // entry 5 waits on tag 7; an unrelated tag 6 must not wake it
    disp(0, 5, 11, 7, 1'b0, 8, 1'b1, 5, 32'h0000_0005);
    step();
    clr_inputs();
    cdb(0, 6);
    step();
    clr_inputs();
    check("e5_wait_empty", 64'(empty_vec), 64'hFFDF);
    cdb(1, 7);
    step();
    clr_inputs();
    check("e5_at_cdb", 64'(issue_valid), 64'd0);
    step();
    check("e5_iv", 64'(issue_valid), 64'b01);
    check("e5_rob", 64'(issue_rob_idx[0]), 64'd5);
    check("e5_dest", 64'(issue_dest_tag[0]), 64'd11);
    step();
    check("e5_drain", 64'(issue_valid), 64'd0);

    // same-cycle CDB bypass on src2 via dispatch slot 1
    disp(1, 7, 12, 3, 1'b1, 9, 1'b0, 7, 32'h0000_0007);
    cdb(1, 9);
    step();
    clr_inputs();
    check("byp_iv_n", 64'(issue_valid), 64'd0);
    check("byp_empty_n", 64'(empty_vec), 64'hFF7F);
    step();
    check("byp_iv", 64'(issue_valid), 64'b01);
    check("byp_rob", 64'(issue_rob_idx[0]), 64'd7);
    check("byp_src2", 64'(issue_src2_tag[0]), 64'd9);
    step();

    // partial FU stall: slot1 holds while slot0 advances
    disp(0, 8, 20, 1, 1'b1, 1, 1'b1, 8, 32'h8);
    disp(1, 9, 21, 1, 1'b1, 1, 1'b1, 9, 32'h9);
    step();
    clr_inputs();
    check("st_free_a", 64'(free_count), 64'd14);
    fu_ready = 2'b01;
    disp(0, 0, 22, 1, 1'b1, 1, 1'b1, 0, 32'h0);
    disp(1, 2, 23, 1, 1'b1, 1, 1'b1, 2, 32'h2);
    step();
    clr_inputs();
    check("st_iv_b", 64'(issue_valid), 64'b11);
    check("st_rob0_b", 64'(issue_rob_idx[0]), 64'd8);
    check("st_rob1_b", 64'(issue_rob_idx[1]), 64'd9);
    fu_ready = 2'b00;
    disp(0, 4, 24, 1, 1'b1, 1, 1'b1, 4, 32'h4);
    step();
    clr_inputs();
    check("st_hold_rob0", 64'(issue_rob_idx[0]), 64'd8);
    check("st_hold_rob1", 64'(issue_rob_idx[1]), 64'd9);
    check("st_free_c", 64'(free_count), 64'd13);
    fu_ready = 2'b01;
    step();
    check("st_d_iv", 64'(issue_valid), 64'b11);
    check("st_d_rob0", 64'(issue_rob_idx[0]), 64'd0);
    check("st_d_rob1", 64'(issue_rob_idx[1]), 64'd9);
    check("st_d_empty", 64'(empty_vec), 64'hFFEB);
    fu_ready = 2'b11;
    step();
    check("st_e_iv", 64'(issue_valid), 64'b11);
    check("st_e_rob0", 64'(issue_rob_idx[0]), 64'd2);
    check("st_e_rob1", 64'(issue_rob_idx[1]), 64'd4);
    check("st_e_empty", 64'(empty_vec), 64'hFFFF);
    step();
    check("st_drain", 64'(issue_valid), 64'd0);

    // fill the bank with entries waiting on tag 20
    for (int c = 0; c < 8; c++) begin
      disp(0, 2 * c, 30, 20, 1'b0, 1, 1'b1, 2 * c, 32'(2 * c));
      disp(1, 2 * c + 1, 31, 20, 1'b0, 1, 1'b1, 2 * c + 1, 32'(2 * c + 1));
      step();
      clr_inputs();
    end
    check("full_empty", 64'(empty_vec), 64'h0000);
    check("full_free", 64'(free_count), 64'd0);
    cdb(0, 20);
    step();
    clr_inputs();
    check("full_wake_iv", 64'(issue_valid), 64'd0);
    step();
    check("full_iss_iv", 64'(issue_valid), 64'b11);
    check("full_iss_rob1", 64'(issue_rob_idx[1]), 64'd1);
    check("full_iss_empty", 64'(empty_vec), 64'h0003);
    fu_ready = 2'b00;
    disp(0, 0, 40, 1, 1'b1, 1, 1'b1, 16, 32'h10);
    disp(1, 1, 41, 1, 1'b1, 1, 1'b1, 17, 32'h11);
    step();
    clr_inputs();
    check("refill_free", 64'(free_count), 64'd0);
    flush = 1'b1;
    disp(0, 0, 42, 1, 1'b1, 1, 1'b1, 18, 32'h12);
    cdb(0, 20);
    step();
    clr_inputs();
    check("flush_free", 64'(free_count), 64'd16);
    check("flush_empty", 64'(empty_vec), 64'hFFFF);
    check("flush_iv", 64'(issue_valid), 64'd0);
    fu_ready = 2'b11;
    step();
    check("flush_drop_iv", 64'(issue_valid), 64'd0);
    check("flush_drop_free", 64'(free_count), 64'd16);

    // asynchronous reset in the middle of a cycle
    disp(0, 6, 13, 1, 1'b1, 1, 1'b1, 6, 32'h6);
    disp(1, 12, 14, 30, 1'b0, 1, 1'b1, 12, 32'hC);
    step();
    clr_inputs();
    step();
    check("ar_pre_iv", 64'(issue_valid), 64'b01);
    check("ar_pre_empty", 64'(empty_vec), 64'hEFFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_empty", 64'(empty_vec), 64'hFFFF);
    check("ar_free", 64'(free_count), 64'd16);
    check("ar_iv", 64'(issue_valid), 64'd0);
    check("ar_rob0", 64'(issue_rob_idx[0]), 64'd0);
    #3;
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
